// File: rtl/alu_stage.sv
// Arithmetic/logic stage behind the accumulator: single-cycle ALU ops plus an
// iterative shift-add multiplier. The registered result is driven onto a tristate bus.
module alu_stage #(
    parameter int WIDTH      = 8,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             start,
    input  logic             out_en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
        OP_XOR = 4'd5, OP_NOT = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8, OP_MUL = 4'd9
    } op_t;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   result;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               is_mul;
    logic               is_nop;
    logic [2*WIDTH-1:0] mul_next;

    assign is_mul   = (alu_op == OP_MUL) && MUL_ENABLE;
    assign is_nop   = (alu_op > OP_MUL) || ((alu_op == OP_MUL) && !MUL_ENABLE);
    assign mul_next = acc + (mplier[0] ? mcand : '0);

    // The bus only ever carries the committed result, never the accumulator
    assign out = out_en ? result : {WIDTH{1'bz}};

    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_ADC: begin
                sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flags[1]};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Extended difference wraps its top bit to 1 exactly on borrow
                sum_ext = {1'b0, a} - {1'b0, b};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[MSB];
            end
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state  <= S_MUL;
                            busy   <= 1'b1;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            done <= 1'b1;
                            if (!is_nop) begin
                                result    <= alu_res;
                                result_hi <= '0;
                                flags     <= {alu_res[MSB], alu_v, alu_c, alu_res == '0};
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last partial product is folded in directly so commit lands on edge k+WIDTH
                    if (cnt == LAST) begin
                        result    <= mul_next[MSB:0];
                        result_hi <= mul_next[2*WIDTH-1:WIDTH];
                        flags     <= {mul_next[MSB], 1'b0,
                                      mul_next[2*WIDTH-1:WIDTH] != '0,
                                      mul_next[MSB:0] == '0};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_stage;
    logic       clock;
    logic       reset_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_op;
    logic       start;
    logic       out_en;
    wire  [7:0] out;
    logic [7:0] result_hi;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    alu_stage #(.WIDTH(8), .MUL_ENABLE(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .alu_op(alu_op),
        .start(start), .out_en(out_en), .out(out), .result_hi(result_hi),
        .flags(flags), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op with start for a single edge; returns #1 after that edge
    task automatic do_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        alu_op = op;
        a      = va;
        b      = vb;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic saw_done;
        reset_n = 1'b0;
        out_en  = 1'b1;
        start   = 1'b0;
        alu_op  = 4'd0;
        a       = 8'h00;
        b       = 8'h00;
        #1;
        chk("reset_out",   16'(out), 16'h0000);
        chk("reset_flags", 16'(flags), 16'h0000);
        chk("reset_busy",  16'(busy), 16'h0000);
        chk("reset_done",  16'(done), 16'h0000);
        chk("reset_hi",    16'(result_hi), 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // ADD with signed overflow
        do_op(4'd0, 8'h7F, 8'h01);
        chk("add_ovf_res",   16'(out), 16'h0080);
        chk("add_ovf_flags", 16'(flags), 16'h000C);
        chk("add_ovf_done",  16'(done), 16'h0001);
        out_en = 1'b0;
        #1;
        checks++;
        assert (out !== 8'h80) else begin
            errors++;
            $error("FAIL bus_release: got %h expected not 80 (tristate)", out);
        end
        out_en = 1'b1;
        @(posedge clock);
        #1;
        chk("done_one_cycle", 16'(done), 16'h0000);

        do_op(4'd0, 8'hFF, 8'h01);
        chk("add_wrap_res",   16'(out), 16'h0000);
        chk("add_wrap_flags", 16'(flags), 16'h0003);

        do_op(4'd2, 8'h00, 8'h01);
        chk("sub_borrow_res",   16'(out), 16'h00FF);
        chk("sub_borrow_flags", 16'(flags), 16'h000A);

        do_op(4'd1, 8'h01, 8'h01);
        chk("adc_res",   16'(out), 16'h0003);
        chk("adc_flags", 16'(flags), 16'h0000);

        // MUL FF*FF = FE01, with an ignored start and operand churn mid-flight
        do_op(4'd9, 8'hFF, 8'hFF);
        chk("mul_busy_k", 16'({busy, done}), 16'h0002);
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                alu_op = 4'd0;
                a      = 8'h05;
                b      = 8'h05;
                start  = 1'b1;
            end else begin
                start = 1'b0;
                a     = 8'(i);
                b     = 8'(i * 3);
            end
            @(posedge clock);
            #1;
            chk($sformatf("mul_busy_%0d", i), 16'({busy, done}), 16'h0002);
            chk($sformatf("mul_bus_%0d", i), 16'(out), 16'h0003);
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("mul_end_busydone", 16'({busy, done}), 16'h0001);
        chk("mul_res", 16'(out), 16'h0001);
        chk("mul_hi",  16'(result_hi), 16'h00FE);
        chk("mul_flags", 16'(flags), 16'h0002);
        @(posedge clock);
        #1;
        chk("mul_done_drop", 16'(done), 16'h0000);

        do_op(4'd3, 8'hFF, 8'h0F);
        chk("and_res",   16'(out), 16'h000F);
        chk("and_hi_clr", 16'(result_hi), 16'h0000);
        chk("and_flags", 16'(flags), 16'h0000);

        do_op(4'd7, 8'h81, 8'h00);
        chk("shl_res",   16'(out), 16'h0002);
        chk("shl_flags", 16'(flags), 16'h0002);

        do_op(4'd6, 8'h0F, 8'h00);
        chk("not_res",   16'(out), 16'h00F0);
        chk("not_flags", 16'(flags), 16'h0008);

        // MUL aborted by reset
        do_op(4'd9, 8'h03, 8'h04);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_res",   16'(out), 16'h0000);
        chk("abort_hi",    16'(result_hi), 16'h0000);
        chk("abort_flags", 16'(flags), 16'h0000);
        chk("abort_busy",  16'({busy, done}), 16'h0000);
        @(negedge clock);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 16'(saw_done), 16'h0000);

        alu_op = 4'd0;
        a      = 8'h02;
        b      = 8'h03;
        start  = 1'b1;
        #1;
        chk("pre_update_bus", 16'(out), 16'h0000);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("add_after_abort", 16'(out), 16'h0005);

        // NOP holds result and flags
        do_op(4'd8, 8'hAB, 8'h00);
        chk("shr_res",   16'(out), 16'h0055);
        chk("shr_flags", 16'(flags), 16'h0002);
        @(posedge clock);
        #1;
        do_op(4'hC, 8'h12, 8'h34);
        chk("nop_done",  16'(done), 16'h0001);
        chk("nop_res",   16'(out), 16'h0055);
        chk("nop_flags", 16'(flags), 16'h0002);
        chk("nop_hi",    16'(result_hi), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
